// File: rtl/bus_demux_register_bank.sv
// Write-side demux into four N-bit holding registers, with a 4-word
// burst loader (stall, busy and done status) for bank initialisation.
module bus_demux_register_bank #(
  parameter int N = 16
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [N-1:0] datain,
  input  logic [1:0]   Select,
  input  logic         WriteEnable,
  input  logic         BurstStart,
  input  logic         Stall,
  output logic [N-1:0] data0out,
  output logic [N-1:0] data1out,
  output logic [N-1:0] data2out,
  output logic [N-1:0] data3out,
  output logic         BurstBusy,
  output logic         BurstDone
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [1:0]         cnt;
  logic [1:0]         cnt_nx;
  logic               done;
  logic               done_nx;
  logic               wr;
  logic [1:0]         wsel;
  logic [3:0][N-1:0]  bank;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    wr       = 1'b0;
    wsel     = Select;
    unique case (state)
      IDLE: begin
        if (BurstStart) begin
          wr       = 1'b1;
          wsel     = 2'd0;
          cnt_nx   = 2'd1;
          state_nx = BURST;
        end else if (WriteEnable) begin
          wr   = 1'b1;
          wsel = Select;
        end
      end
      BURST: begin
        if (!Stall) begin
          wr   = 1'b1;
          wsel = cnt;
          if (cnt == 2'd3) begin
            cnt_nx   = 2'd0;
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = cnt + 2'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= 2'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bank <= '0;
    end else if (wr) begin
      bank[wsel] <= datain;
    end
  end

  assign data0out  = bank[0];
  assign data1out  = bank[1];
  assign data2out  = bank[2];
  assign data3out  = bank[3];
  assign BurstBusy = (state == BURST);
  assign BurstDone = done;

endmodule

// File: tb/tb_bus_demux_register_bank.sv
// Directed bench for bus_demux_register_bank: single writes, bursts,
// stalls, priority, back-to-back bursts and async reset.
module tb_bus_demux_register_bank;

  localparam int N = 16;

  logic         Clock;
  logic         Reset;
  logic [N-1:0] datain;
  logic [1:0]   Select;
  logic         WriteEnable;
  logic         BurstStart;
  logic         Stall;
  logic [N-1:0] data0out;
  logic [N-1:0] data1out;
  logic [N-1:0] data2out;
  logic [N-1:0] data3out;
  logic         BurstBusy;
  logic         BurstDone;

  int checks;
  int errors;

  bus_demux_register_bank #(.N(N)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .datain      (datain),
    .Select      (Select),
    .WriteEnable (WriteEnable),
    .BurstStart  (BurstStart),
    .Stall       (Stall),
    .data0out    (data0out),
    .data1out    (data1out),
    .data2out    (data2out),
    .data3out    (data3out),
    .BurstBusy   (BurstBusy),
    .BurstDone   (BurstDone)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [4*N+1:0] obs();
    return {data0out, data1out, data2out, data3out, BurstBusy, BurstDone};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    datain = '0;
    Select = '0;
    WriteEnable = 1'b0;
    BurstStart = 1'b0;
    Stall = 1'b0;
    #3;
    checks++;
    if (obs() !== {64'h0, 2'b00}) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs(), {64'h0, 2'b00});
    end
    step();
    step();
    Reset = 1'b1;
    step();
    checks++;
    if (obs() !== {64'h0, 2'b00}) begin
      errors++;
      $display("FAIL reset_release_idle: got %h want %h", obs(), {64'h0, 2'b00});
    end
  endtask

  task automatic test_single_write();
    WriteEnable = 1'b1;
    Select = 2'd2;
    datain = 16'hBEEF;
    step();
    checks++;
    if (obs() !== {16'h0, 16'h0, 16'hBEEF, 16'h0, 2'b00}) begin
      errors++;
      $display("FAIL single_sel2: got %h", obs());
    end
    Select = 2'd0;
    datain = 16'h1234;
    step();
    WriteEnable = 1'b0;
    checks++;
    if (obs() !== {16'h1234, 16'h0, 16'hBEEF, 16'h0, 2'b00}) begin
      errors++;
      $display("FAIL single_sel0: got %h", obs());
    end
    datain = 16'h7777;
    step();
    checks++;
    if (obs() !== {16'h1234, 16'h0, 16'hBEEF, 16'h0, 2'b00}) begin
      errors++;
      $display("FAIL single_hold: got %h", obs());
    end
  endtask

  task automatic test_burst();
    int busy_cnt;
    int done_cnt;
    logic [15:0] words [4];
    words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    busy_cnt = 0;
    done_cnt = 0;
    BurstStart = 1'b1;
    datain = words[0];
    step();
    BurstStart = 1'b0;
    checks++;
    if (obs() !== {16'h0011, 16'h0, 16'hBEEF, 16'h0, 2'b10}) begin
      errors++;
      $display("FAIL burst_word0: got %h", obs());
    end
    for (int i = 1; i < 4; i++) begin
      busy_cnt += int'(BurstBusy);
      datain = words[i];
      step();
    end
    checks++;
    if (obs() !== {16'h0011, 16'h0022, 16'h0033, 16'h0044, 2'b01}) begin
      errors++;
      $display("FAIL burst_final: got %h", obs());
    end
    for (int i = 0; i < 3; i++) begin
      done_cnt += int'(BurstDone);
      busy_cnt += int'(BurstBusy);
      step();
    end
    checks++;
    if (busy_cnt !== 3) begin
      errors++;
      $display("FAIL burst_busy_len: got %0d want 3", busy_cnt);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL burst_done_len: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_stall();
    int busy_cnt;
    busy_cnt = 0;
    BurstStart = 1'b1;
    Stall = 1'b1;
    datain = 16'h0101;
    step();
    BurstStart = 1'b0;
    Stall = 1'b0;
    busy_cnt += int'(BurstBusy);
    datain = 16'h0202;
    step();
    busy_cnt += int'(BurstBusy);
    Stall = 1'b1;
    WriteEnable = 1'b1;
    Select = 2'd3;
    datain = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      step();
      busy_cnt += int'(BurstBusy);
      checks++;
      if (obs() !== {16'h0101, 16'h0202, 16'h0033, 16'h0044, 2'b10}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h", i, obs());
      end
    end
    Stall = 1'b0;
    WriteEnable = 1'b0;
    datain = 16'h0303;
    step();
    busy_cnt += int'(BurstBusy);
    datain = 16'h0404;
    step();
    busy_cnt += int'(BurstBusy);
    checks++;
    if (obs() !== {16'h0101, 16'h0202, 16'h0303, 16'h0404, 2'b01}) begin
      errors++;
      $display("FAIL stall_final: got %h", obs());
    end
    checks++;
    if (busy_cnt !== 5) begin
      errors++;
      $display("FAIL stall_busy_len: got %0d want 5", busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    step();
    BurstStart = 1'b1;
    WriteEnable = 1'b1;
    Select = 2'd2;
    datain = 16'h0A0A;
    step();
    BurstStart = 1'b0;
    WriteEnable = 1'b0;
    checks++;
    if (obs() !== {16'h0A0A, 16'h0202, 16'h0303, 16'h0404, 2'b10}) begin
      errors++;
      $display("FAIL prio_burst_over_write: got %h", obs());
    end
    datain = 16'h0B0B;
    step();
    datain = 16'h0C0C;
    step();
    datain = 16'h0D0D;
    step();
    checks++;
    if (obs() !== {16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 2'b01}) begin
      errors++;
      $display("FAIL b2b_first_done: got %h", obs());
    end
    BurstStart = 1'b1;
    datain = 16'h0E0E;
    step();
    BurstStart = 1'b0;
    checks++;
    if (obs() !== {16'h0E0E, 16'h0B0B, 16'h0C0C, 16'h0D0D, 2'b10}) begin
      errors++;
      $display("FAIL b2b_restart: got %h", obs());
    end
    datain = 16'h0F0F;
    step();
    datain = 16'h1010;
    step();
    datain = 16'h1111;
    step();
    checks++;
    if (obs() !== {16'h0E0E, 16'h0F0F, 16'h1010, 16'h1111, 2'b01}) begin
      errors++;
      $display("FAIL b2b_second_done: got %h", obs());
    end
    WriteEnable = 1'b1;
    Select = 2'd3;
    datain = 16'h2222;
    step();
    WriteEnable = 1'b0;
    checks++;
    if (obs() !== {16'h0E0E, 16'h0F0F, 16'h1010, 16'h2222, 2'b00}) begin
      errors++;
      $display("FAIL write_after_done: got %h", obs());
    end
  endtask

  task automatic test_reset_mid_burst();
    BurstStart = 1'b1;
    datain = 16'hAAAA;
    step();
    BurstStart = 1'b0;
    datain = 16'hBBBB;
    step();
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if (obs() !== {64'h0, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_burst: got %h want 0", obs());
    end
    Reset = 1'b1;
    WriteEnable = 1'b1;
    Select = 2'd1;
    datain = 16'h5A5A;
    step();
    WriteEnable = 1'b0;
    checks++;
    if (obs() !== {16'h0, 16'h5A5A, 16'h0, 16'h0, 2'b00}) begin
      errors++;
      $display("FAIL write_after_reset: got %h", obs());
    end
    datain = 16'hC3C3;
    step();
    checks++;
    if (obs() !== {16'h0, 16'h5A5A, 16'h0, 16'h0, 2'b00}) begin
      errors++;
      $display("FAIL no_resume_after_reset: got %h", obs());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_write();
    test_burst();
    test_stall();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_demux_register_bank.md
# bus_demux_register_bank

Write-side counterpart of the CPU's 4-to-1 bus read mux. The block steers one N-bit input bus into one of four N-bit holding registers, selected by a 2-bit address. Its four register outputs feed the 4-to-1 read mux directly. It also provides a burst mode that loads all four registers from four consecutive bus words, with stall support and busy/done status. This mode is used to initialise register banks from switch inputs or a loader.

## Interface

Parameters:
- N, 16, bus and register width

Ports:
- Clock  input  1  single system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-low reset
- datain  input  N  write data bus
- Select  input  2  target register for single writes (0..3)
- WriteEnable  input  1  single-write request, sampled on rising edge
- BurstStart  input  1  start a 4-word burst load, sampled on rising edge
- Stall  input  1  burst pause; holds the burst counter, suppresses the write
- data0out, data1out, data2out, data3out  output  N each  register contents
- BurstBusy  output  1  high while the burst state machine is in BURST
- BurstDone  output  1  one-cycle pulse after the last burst word is written

## Operation

- State machine has two states: IDLE and BURST. It also keeps a 2-bit burst counter `cnt` and a registered `done` flag.
- IDLE, BurstStart=1:
  - reg0 <= datain
  - cnt <= 1
  - go to BURST
  - WriteEnable and Select are ignored that cycle, so burst has priority.
- IDLE, BurstStart=0, WriteEnable=1:
  - reg[Select] <= datain
  - the other three registers hold.
- IDLE, both low: all registers hold.
- BURST, Stall=1: no write; `cnt` and state hold.
- BURST, Stall=0:
  - reg[cnt] <= datain
  - if cnt==3: `cnt` wraps to 0, state goes to IDLE, and `done` is set for one cycle
  - otherwise cnt <= cnt+1
- In BURST, WriteEnable, Select and BurstStart are ignored.
- Register widths are exactly N. There is no sign extension or truncation.
- Reset (Reset=0) takes effect immediately, independent of Clock:
  - all four registers = 0
  - state = IDLE, cnt = 0, done = 0
  - this applies mid-burst as well; the partial burst is discarded, not resumed.

## Timing

- Reset values: data0out..data3out = 0, BurstBusy = 0, BurstDone = 0.
- data*out are direct register outputs. A write is visible in the cycle after the capturing edge. There is no combinational path from datain to data*out.
- BurstBusy = (state == BURST). It is decoded from registered state, so it goes high the cycle after BurstStart is sampled.
- Unstalled burst latency:
  - edge 0 writes reg0
  - edges 1–3 write reg1–reg3
  - BurstBusy is high for 3 cycles (after edges 0, 1, 2)
  - BurstDone is high for exactly 1 cycle, after edge 3
- Each stalled cycle in BURST adds one cycle to BurstBusy and delays BurstDone by one cycle.
- Stall during the IDLE/BurstStart cycle has no effect; the reg0 write still occurs.
- BurstStart in the BurstDone cycle is legal and starts a new burst. That edge writes reg0 and clears BurstDone.
- A single write during the BurstDone cycle is legal.
- Release of Reset is treated as synchronous to Clock. The first valid capture is on the first edge after deassertion.

## Test plan

- Reset check: assert Reset=0 mid-run with arbitrary register contents -> all data*out = 0x0000, BurstBusy = 0, BurstDone = 0 with no clock edge needed.
- Single writes: WriteEnable=1 with Select=2, datain=0xBEEF, then Select=0, datain=0x1234 -> data2out = 0xBEEF and data0out = 0x1234 one cycle after each edge; data1out and data3out stay 0.
- Unstalled burst: BurstStart=1, then datain 0x0011, 0x0022, 0x0033, 0x0044 on consecutive edges -> data0out..data3out = 0x0011..0x0044, BurstBusy high 3 cycles, BurstDone high exactly 1 cycle.
- Burst with stall and ignored inputs: stall 2 cycles after word 1, and drive WriteEnable=1, Select=3, datain=0xFFFF during the stall -> no register changes during the stall, BurstBusy high 5 cycles, final contents equal the four burst words, no 0xFFFF anywhere.
- Priority and back-to-back: BurstStart=1 and WriteEnable=1 with Select=2 on the same edge -> reg0 is written and reg2 is untouched; BurstStart=1 again in the BurstDone cycle -> a second burst starts and BurstDone drops.
- Reset mid-burst: Reset=0 after 2 burst words -> all registers 0 and BurstBusy 0; after release a single write to Select=1 works normally.
